acc_result_streamer: RTL and testbench
======================================

Name: acc_result_streamer

Overview:
- Output stage directly downstream of the matrix accelerator top level.
- On each accelerator done pulse, captures one result record: softmax_out, quantized_data_wire and vec_max_wire.
- Buffers records in a small FIFO and serializes each one as 9 beats of 32 bits on a valid/ready stream toward the host/DMA interface.
- Provides backpressure status and a sticky overflow indication, because the accelerator has no stall input on its output side.

Parameters:
- DEPTH, 4, number of 288-bit record slots in the FIFO (power of 2, ≥2).
- CNT_W, 3, width of the fill-level output; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-high (asserted = 1, despite the name); clears all state.
- done_in  input  1  one-cycle capture strobe, driven from the accelerator done_wire.
- softmax_in  input  128  softmax_out of the accelerator.
- quant_in  input  136  quantized_data_wire of the accelerator.
- vmax_in  input  16  vec_max_wire of the accelerator.
- out_data  output  32  current beat.
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- out_last  output  1  high on beat 8 of a record.
- fill_level  output  CNT_W  records currently stored, including the record being streamed.
- full  output  1  fill_level == DEPTH.
- overflow  output  1  sticky; set when a record is dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset values: out_data=0, out_valid=0, out_last=0, fill_level=0, full=0, overflow=0. The read FSM is in IDLE and the beat index is 0.
- Reset asserted mid-record discards all stored and partially sent data. No beat is presented until a new done_in arrives.
- Record layout, 288 bits: R = {vmax_in[15:0], 8'h00, quant_in[135:0], softmax_in[127:0]}.
- Beat k (k=0..8) = R[32k+31:32k]. Beats 0-3 carry softmax, beats 4-7 carry quant[127:0], beat 8 = {vmax, 8'h00, quant[135:128]}.
- Write side:
  - A rising edge with done_in=1 and the FIFO not full writes R into the write slot and increments the write pointer modulo DEPTH.
  - Inputs are sampled only in the done_in cycle; they may change afterwards.
- Full write:
  - done_in while full and no pop in the same cycle drops the record and sets overflow=1. Stored data is unchanged.
  - done_in while full, in the same cycle the final beat (beat 8) is accepted, is NOT a drop. Pop and push both occur and fill_level stays DEPTH.
- Read FSM:
  - IDLE → SEND when fill_level > 0. out_valid rises on the cycle after the write edge, giving 1-cycle latency from the done_in edge to the first beat.
  - In SEND: out_valid=1 and out_data = beat[idx] of the head slot.
  - On accept with idx<8: idx increments.
  - On accept with idx==8: the slot is popped, idx returns to 0, and the FSM stays in SEND if another record remains, otherwise returns to IDLE.
  - Records stream back-to-back with no bubble cycles.
- Stability rule: while out_valid && !out_ready, out_data, out_last and idx hold. out_valid never drops without an accept.
- out_last = SEND && idx==8.
- fill_level is registered and updates on each push and on each final-beat pop. A simultaneous push and pop leaves it unchanged.
- overflow:
  - Cleared by clr_ovf=1 at the edge.
  - If a drop and clr_ovf happen in the same cycle, the set wins and overflow=1.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by fill_level, not by pointer equality.

Test Plan:
- Reset, then one done_in with softmax=128'h0F..0F_0001, quant=136'hAB<<128 | 1, vmax=16'h3C00, out_ready held 1:
  - First beat appears the next cycle: beat0=32'h0000_0001, beat4=32'h0000_0001, beat8=32'h3C00_00AB with out_last=1.
  - Nine consecutive valid cycles, then out_valid=0 and fill_level=0.
- Backpressure: out_ready toggled 1,0,0,1,... during a record → out_data is unchanged in every stalled cycle, and exactly 9 beats are accepted in order.
- Fill: 4 done_in pulses with out_ready=0 → fill_level=4, full=1. A 5th done_in sets overflow=1 and fill_level stays 4. Draining yields records 1-4 intact (36 beats, 4 out_last).
- Simultaneous: full FIFO, done_in in the same cycle as the beat-8 accept → overflow stays 0, fill_level stays 4, and the new record is streamed last.
- Overflow clear: clr_ovf=1 in the same cycle as a drop → overflow=1. clr_ovf alone on the next cycle → overflow=0.
- Reset asserted after beat 3 of a record with 2 records stored → all outputs return to their reset values asynchronously, and the next done_in streams from beat 0 of the new record only.

Source files
------------

// File: rtl/acc_result_streamer.sv
// acc_result_streamer
//   Output stage behind the matrix accelerator. Each done_in pulse captures
//   one 288-bit result record {vmax, 8'h00, quant, softmax} into a small FIFO.
//   The record is then sent to the host/DMA side as 9 beats of 32 bits on a
//   valid/ready stream, lowest word first.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous reset, ACTIVE-HIGH despite the name
//   done_in    : one-cycle capture strobe from the accelerator
//   softmax_in : 128-bit softmax result
//   quant_in   : 136-bit quantized data
//   vmax_in    : 16-bit vector maximum
//   out_data   : current 32-bit beat
//   out_valid  : beat valid
//   out_ready  : consumer accepts the beat when out_valid && out_ready
//   out_last   : high on beat 8 of a record
//   fill_level : records stored, including the one being streamed
//   full       : fill_level == DEPTH
//   overflow   : sticky, set when a record is dropped on a full FIFO
//   clr_ovf    : synchronous clear of overflow (a same-cycle drop wins)
module acc_result_streamer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             done_in,
  input  logic [127:0]     softmax_in,
  input  logic [135:0]     quant_in,
  input  logic [15:0]      vmax_in,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] fill_level,
  output logic             full,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_nxt;
  logic [8:0][31:0]       mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [3:0]             idx;
  logic                   last_beat, push, pop, drop;

  always_comb begin
    state_nxt = state;
    last_beat = (state == SEND) && (idx == 4'd8);
    pop       = last_beat && out_ready;
    full      = (fill_level == CNT_W'(DEPTH));
    // Popping the head in the same cycle frees a slot, so a full FIFO can
    // still accept the new record without a drop.
    push      = done_in && (!full || pop);
    drop      = done_in && full && !pop;

    unique case (state)
      // Going to SEND on the push edge itself gives the first beat on the
      // cycle right after the done_in edge.
      IDLE: if (push) state_nxt = SEND;
      SEND: if (pop && !push && (fill_level == CNT_W'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    out_valid = (state == SEND);
    out_last  = last_beat;
    out_data  = (state == SEND) ? mem[rd_ptr][idx] : '0;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      idx        <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;

      if (push) begin
        mem[wr_ptr] <= {vmax_in, 8'h00, quant_in, softmax_in};
        wr_ptr      <= wr_ptr + 1'b1;
      end

      if (pop) rd_ptr <= rd_ptr + 1'b1;

      if ((state == SEND) && out_ready) idx <= last_beat ? 4'd0 : idx + 4'd1;

      if (push && !pop)      fill_level <= fill_level + 1'b1;
      else if (pop && !push) fill_level <= fill_level - 1'b1;

      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_result_streamer.sv
module tb_acc_result_streamer;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         done_in;
  logic [127:0] softmax_in;
  logic [135:0] quant_in;
  logic [15:0]  vmax_in;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [2:0]   fill_level;
  logic         full;
  logic         overflow;
  logic         clr_ovf;

  int n_vec = 0;
  int n_err = 0;

  acc_result_streamer #(.DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .done_in    (done_in),
    .softmax_in (softmax_in),
    .quant_in   (quant_in),
    .vmax_in    (vmax_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .fill_level (fill_level),
    .full       (full),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: act=%h req=%h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model: a queue of whole records ----------------
  logic [287:0] recs[$];
  int           m_beat;
  bit           m_ovf;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      recs.delete();
      m_beat = 0;
      m_ovf  = 0;
    end else begin
      bit have, pop, acc, do_push, do_drop;
      have    = recs.size() > 0;
      acc     = have && out_ready;
      pop     = acc && (m_beat == 8);
      do_push = done_in && (recs.size() < DEPTH || pop);
      do_drop = done_in && !do_push;
      if (acc) m_beat = pop ? 0 : m_beat + 1;
      if (do_drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (pop) void'(recs.pop_front());
      if (do_push) recs.push_back({vmax_in, 8'h00, quant_in, softmax_in});
    end
  end

  // Compare process: every cycle out of reset, all outputs against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      logic [287:0] head;
      logic [31:0]  ebeat;
      bit           ev;
      ev    = recs.size() > 0;
      head  = ev ? recs[0] : '0;
      ebeat = head[32*m_beat +: 32];
      chk("m_valid", {31'd0, out_valid}, {31'd0, ev});
      chk("m_fill",  {29'd0, fill_level}, 32'(recs.size()));
      chk("m_full",  {31'd0, full}, {31'd0, recs.size() == DEPTH});
      chk("m_ovf",   {31'd0, overflow}, {31'd0, m_ovf});
      chk("m_last",  {31'd0, out_last}, {31'd0, ev && m_beat == 8});
      if (ev) chk("m_data", out_data, ebeat);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [127:0] s, input logic [135:0] q, input logic [15:0] v);
    done_in = 1'b1; softmax_in = s; quant_in = q; vmax_in = v;
    tick();
    done_in = 1'b0; softmax_in = ~s; quant_in = ~q; vmax_in = ~v;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 100) begin
      tick();
      n++;
    end
    chk(name, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    bit          stalled;
    int          accepted, lasts, n;
    bit          pat [4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

    rst_n = 1'b1; done_in = 0; softmax_in = '0; quant_in = '0; vmax_in = '0;
    out_ready = 0; clr_ovf = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  out_data, 32'd0);
    chk("rst_fill",  {29'd0, fill_level}, 32'd0);
    chk("rst_ovf",   {31'd0, overflow}, 32'd0);
    #2 rst_n = 1'b0;
    tick();

    // Single record, ready held high
    out_ready = 1'b1;
    put(128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_00000001, {8'hAB, 128'h1}, 16'h3C00);
    chk("t1_first_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_beat0", out_data, 32'h0000_0001);
    repeat (4) tick();
    chk("t1_beat4", out_data, 32'h0000_0001);
    repeat (4) tick();
    chk("t1_beat8", out_data, 32'h3C00_00AB);
    chk("t1_last",  {31'd0, out_last}, 32'd1);
    tick();
    chk("t1_end_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_end_fill",  {29'd0, fill_level}, 32'd0);

    // Backpressure with ready pattern 1,0,0,1
    put(128'h11111111_22222222_33333333_44444444, {8'h5A, 128'h55555555_66666666_77777777_88888888}, 16'h1234);
    accepted = 0; stalled = 0; prev = '0; n = 0;
    while (out_valid && n < 60) begin
      out_ready = pat[n % 4];
      if (stalled) chk("bp_hold", out_data, prev);
      stalled = !out_ready;
      prev    = out_data;
      if (out_ready) accepted++;
      tick();
      n++;
    end
    chk("bp_beats", 32'(accepted), 32'd9);

    // Fill to DEPTH with ready low, then drop
    out_ready = 1'b0;
    for (int r = 1; r <= 4; r++)
      put({4{32'(r * 16'h0101)}}, {8'(r), {4{32'(r * 16'h1010)}}}, 16'(r));
    chk("fill_level4", {29'd0, fill_level}, 32'd4);
    chk("fill_full",   {31'd0, full}, 32'd1);
    put({4{32'hDEAD_BEEF}}, '1, 16'hFFFF);
    chk("drop_ovf",  {31'd0, overflow}, 32'd1);
    chk("drop_fill", {29'd0, fill_level}, 32'd4);

    // Clear racing a drop: set wins; clear alone then works
    clr_ovf = 1'b1;
    put({4{32'hBAD0_0000}}, '0, 16'h0);
    chk("clr_race_ovf", {31'd0, overflow}, 32'd1);
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", {31'd0, overflow}, 32'd0);

    // Simultaneous push and final-beat pop on a full FIFO
    out_ready = 1'b1;
    n = 0;
    while (!out_last && n < 20) begin
      tick();
      n++;
    end
    chk("sim_at_last", {31'd0, out_last}, 32'd1);
    put({4{32'hC0DE_0005}}, {8'h05, {4{32'h0505_0505}}}, 16'h0005);
    chk("sim_ovf",  {31'd0, overflow}, 32'd0);
    chk("sim_fill", {29'd0, fill_level}, 32'd4);
    lasts = 0; n = 0;
    while (out_valid && n < 100) begin
      if (out_last) lasts++;
      if (fill_level == 3'd1 && idx_zero_probe()) chk("sim_newlast", out_data, 32'hC0DE_0005);
      tick();
      n++;
    end
    chk("sim_lasts", 32'(lasts), 32'd4);
    chk("sim_empty", {29'd0, fill_level}, 32'd0);

    // Asynchronous reset mid-record with two records stored
    out_ready = 1'b1;
    put({4{32'hAAAA_0001}}, '0, 16'h1);
    put({4{32'hBBBB_0002}}, '0, 16'h2);
    repeat (3) tick();
    #2 rst_n = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data",  out_data, 32'd0);
    chk("arst_last",  {31'd0, out_last}, 32'd0);
    chk("arst_fill",  {29'd0, fill_level}, 32'd0);
    chk("arst_full",  {31'd0, full}, 32'd0);
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("arst_idle", {31'd0, out_valid}, 32'd0);
    put({32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001}, '0, 16'h7);
    chk("arst_new_beat0", out_data, 32'h1111_0001);
    tick();
    chk("arst_new_beat1", out_data, 32'h2222_0002);
    drain("arst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // True when the beat on the bus is the first beat of the head record,
  // derived from the model's beat counter rather than the DUT.
  function automatic bit idx_zero_probe();
    return m_beat == 0;
  endfunction

endmodule
